// File: rtl/inst_mem_responder_pkg.sv
// inst_mem_responder_pkg: shared widths, default depth and FSM state encoding for the fetch responder.
package inst_mem_responder_pkg;
  localparam int DEF_ADDRESS_LEN = 32;
  localparam int DEF_INSTRUCTION_LEN = 32;
  localparam int INST_MEM_DEPTH = 1024;
  localparam int DEF_LATENCY = 2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;
  function automatic logic [3:0] wait_init(input int latency);
    return 4'(latency - 1);
  endfunction
endpackage

// File: rtl/inst_mem_array.sv
// inst_mem_array: instruction word store with synchronous write and combinational read.
module inst_mem_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: fetch-side memory responder with programmable wait states, flush abort and a program-load port.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter int ADDRESS_LEN     = DEF_ADDRESS_LEN,
  parameter int INSTRUCTION_LEN = DEF_INSTRUCTION_LEN,
  parameter int DEPTH           = INST_MEM_DEPTH,
  parameter int LATENCY         = DEF_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [ADDRESS_LEN-1:0]     req_addr,
  output logic                       req_ready,
  input  logic                       flush,
  output logic                       resp_valid,
  output logic [INSTRUCTION_LEN-1:0] resp_data,
  input  logic                       resp_ready,
  input  logic                       load_en,
  input  logic [ADDRESS_LEN-1:0]     load_addr,
  input  logic [INSTRUCTION_LEN-1:0] load_data,
  output logic                       busy
);
  localparam int IW = $clog2(DEPTH);
  state_e                     state_q;
  logic [3:0]                 cnt_q;
  logic [IW-1:0]              idx_q;
  logic                       oor_q;
  logic                       valid_q;
  logic [INSTRUCTION_LEN-1:0] data_q;
  logic [IW-1:0]              req_idx, load_idx, raddr;
  logic                       req_oor, load_oor, we, accept;
  logic [INSTRUCTION_LEN-1:0] rdata, accept_data;
  logic                       unused_addr_lsbs;
  assign req_idx   = req_addr[IW+1:2];
  assign load_idx  = load_addr[IW+1:2];
  assign req_oor   = |(req_addr >> (IW + 2));
  assign load_oor  = |(load_addr >> (IW + 2));
  assign unused_addr_lsbs = ^{req_addr[1:0], load_addr[1:0]};
  assign req_ready = rst && state_q == IDLE && !flush;
  assign accept    = req_valid && req_ready;
  assign we        = load_en && state_q == IDLE && !load_oor;
  assign raddr     = state_q == IDLE ? req_idx : idx_q;
  // Single-cycle builds read at accept, so a same-edge load must be forwarded.
  assign accept_data = req_oor ? '0 : (we && load_idx == req_idx) ? load_data : rdata;
  assign busy       = state_q != IDLE;
  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  inst_mem_array #(
    .DEPTH(DEPTH),
    .WIDTH(INSTRUCTION_LEN)
  ) u_array (
    .clk    (clk),
    .we_i   (we),
    .waddr_i(load_idx),
    .wdata_i(load_data),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (state_q != IDLE && flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          idx_q <= req_idx;
          oor_q <= req_oor;
          cnt_q <= wait_init(LATENCY);
          if (LATENCY == 1) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            data_q  <= accept_data;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            data_q  <= oor_q ? '0 : rdata;
          end
        end
        RESP: if (resp_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: directed table-driven bench over LATENCY=2, 4 and 1 builds of inst_mem_responder.
module tb_inst_mem_responder;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          hold;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] rv = '0, fl = '0, pp = '0, le = '0;
  logic [2:0][31:0] ra = '0, la = '0, ld = '0;
  logic v0, v1, v2, r0, r1, r2, b0, b1, b2;
  logic [31:0] d0, d1, d2;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  inst_mem_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst_n), .req_valid(rv[0]), .req_addr(ra[0]), .req_ready(r0),
    .flush(fl[0]), .resp_valid(v0), .resp_data(d0), .resp_ready(pp[0]),
    .load_en(le[0]), .load_addr(la[0]), .load_data(ld[0]), .busy(b0)
  );
  inst_mem_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst_n), .req_valid(rv[1]), .req_addr(ra[1]), .req_ready(r1),
    .flush(fl[1]), .resp_valid(v1), .resp_data(d1), .resp_ready(pp[1]),
    .load_en(le[1]), .load_addr(la[1]), .load_data(ld[1]), .busy(b1)
  );
  inst_mem_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst_n), .req_valid(rv[2]), .req_addr(ra[2]), .req_ready(r2),
    .flush(fl[2]), .resp_valid(v2), .resp_data(d2), .resp_ready(pp[2]),
    .load_en(le[2]), .load_addr(la[2]), .load_data(ld[2]), .busy(b2)
  );
  function automatic int lat_of(input int d);
    return d == 0 ? 2 : d == 1 ? 4 : 1;
  endfunction
  function automatic logic [31:0] vld(input int d);
    return {31'd0, d == 0 ? v0 : d == 1 ? v1 : v2};
  endfunction
  function automatic logic [31:0] rdy(input int d);
    return {31'd0, d == 0 ? r0 : d == 1 ? r1 : r2};
  endfunction
  function automatic logic [31:0] bsy(input int d);
    return {31'd0, d == 0 ? b0 : d == 1 ? b1 : b2};
  endfunction
  function automatic logic [31:0] dat(input int d);
    return d == 0 ? d0 : d == 1 ? d1 : d2;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic load(input int d, input logic [31:0] a, input logic [31:0] w);
    le[d] = 1'b1;
    la[d] = a;
    ld[d] = w;
    step();
    le[d] = 1'b0;
  endtask
  task automatic handshake(input int d, input string nm);
    pp[d] = 1'b1;
    step();
    pp[d] = 1'b0;
    #1;
    chk({nm, "-post-valid"}, vld(d), 0);
    chk({nm, "-post-busy"}, bsy(d), 0);
    chk({nm, "-post-ready"}, rdy(d), 1);
  endtask
  task automatic fetch(input int d, input logic [31:0] a, input int hold, input logic [31:0] exp, input string nm);
    rv[d] = 1'b1;
    ra[d] = a;
    #1;
    chk({nm, "-ready"}, rdy(d), 1);
    step();
    rv[d] = 1'b0;
    for (int i = 0; i < lat_of(d) - 1; i++) begin
      chk({nm, "-wait-valid"}, vld(d), 0);
      chk({nm, "-wait-busy"}, bsy(d), 1);
      step();
    end
    chk({nm, "-valid"}, vld(d), 1);
    chk({nm, "-data"}, dat(d), exp);
    chk({nm, "-resp-ready"}, rdy(d), 0);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({nm, "-hold-valid"}, vld(d), 1);
      chk({nm, "-hold-data"}, dat(d), exp);
    end
    handshake(d, nm);
  endtask
  vec_t loads[5];
  vec_t reads[6];
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    loads[0] = '{32'h0000_0000, 32'hE3A0_0001, 0};
    loads[1] = '{32'h0000_0004, 32'hE280_0002, 0};
    loads[2] = '{32'h0000_0008, 32'h1234_5678, 0};
    loads[3] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 0};
    loads[4] = '{32'h0000_1000, 32'hBADB_AD00, 0};
    reads[0] = '{32'h0000_0004, 32'hE280_0002, 0};
    reads[1] = '{32'h0000_0000, 32'hE3A0_0001, 5};
    reads[2] = '{32'h0000_0009, 32'h1234_5678, 0};
    reads[3] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 1};
    reads[4] = '{32'h0001_0000, 32'h0000_0000, 0};
    reads[5] = '{32'h0000_1000, 32'h0000_0000, 0};
    @(negedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset-valid", vld(d), 0);
      chk("reset-data", dat(d), 0);
      chk("reset-ready", rdy(d), 0);
      chk("reset-busy", bsy(d), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 5; i++) load(d, loads[i].addr, loads[i].data);
    for (int i = 0; i < 6; i++) fetch(0, reads[i].addr, reads[i].hold, reads[i].data, $sformatf("tbl%0d", i));
    // flush one cycle into WAIT on the 4-cycle build
    rv[1] = 1'b1;
    ra[1] = 32'h0;
    step();
    rv[1] = 1'b0;
    chk("fw-busy", bsy(1), 1);
    fl[1] = 1'b1;
    step();
    fl[1] = 1'b0;
    chk("fw-idle", bsy(1), 0);
    for (int i = 0; i < 6; i++) begin
      chk("fw-novalid", vld(1), 0);
      step();
    end
    fetch(1, 32'h0, 0, 32'hE3A0_0001, "fw-next");
    // flush with a request in IDLE blocks acceptance for that cycle only
    rv[0] = 1'b1;
    ra[0] = 32'h4;
    fl[0] = 1'b1;
    #1;
    chk("fi-ready", rdy(0), 0);
    step();
    chk("fi-notaccepted", bsy(0), 0);
    fl[0] = 1'b0;
    #1;
    chk("fi-ready2", rdy(0), 1);
    step();
    rv[0] = 1'b0;
    chk("fi-accepted", bsy(0), 1);
    chk("fi-wait", vld(0), 0);
    step();
    chk("fi-valid", vld(0), 1);
    chk("fi-data", dat(0), 32'hE280_0002);
    handshake(0, "fi");
    // load strobe during WAIT must be ignored
    rv[1] = 1'b1;
    ra[1] = 32'h4;
    step();
    rv[1] = 1'b0;
    load(1, 32'h4, 32'h1111_1111);
    step();
    step();
    chk("lw-valid", vld(1), 1);
    chk("lw-data", dat(1), 32'hE280_0002);
    handshake(1, "lw");
    fetch(1, 32'h4, 0, 32'hE280_0002, "lw-reread");
    // flush and resp_ready together in RESP
    rv[0] = 1'b1;
    ra[0] = 32'h0;
    step();
    rv[0] = 1'b0;
    step();
    chk("fr-valid", vld(0), 1);
    fl[0] = 1'b1;
    pp[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    pp[0] = 1'b0;
    chk("fr-gone", vld(0), 0);
    chk("fr-idle", bsy(0), 0);
    // simultaneous load and accept to the same index returns the new word
    for (int d = 0; d < 3; d += 2) begin
      rv[d] = 1'b1;
      ra[d] = 32'h8;
      le[d] = 1'b1;
      la[d] = 32'h8;
      ld[d] = 32'hCAFE_F00D;
      step();
      rv[d] = 1'b0;
      le[d] = 1'b0;
      for (int i = 0; i < lat_of(d) - 1; i++) step();
      chk("la-valid", vld(d), 1);
      chk("la-data", dat(d), 32'hCAFE_F00D);
      handshake(d, "la");
    end
    // asynchronous reset in RESP
    rv[0] = 1'b1;
    ra[0] = 32'h0;
    step();
    rv[0] = 1'b0;
    step();
    chk("ar-valid-before", vld(0), 1);
    chk("ar-data-before", dat(0), 32'hE3A0_0001);
    #2 rst_n = 1'b0;
    #1;
    chk("ar-valid", vld(0), 0);
    chk("ar-data", dat(0), 0);
    chk("ar-ready", rdy(0), 0);
    chk("ar-busy", bsy(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fetch(0, 32'h4, 0, 32'hE280_0002, "ar-l2");
    fetch(2, 32'h4, 0, 32'hE280_0002, "ar-l1");
    fetch(2, 32'h0FFC, 2, 32'hDEAD_BEEF, "ar-l1-top");
    fetch(1, 32'h0, 0, 32'hE3A0_0001, "ar-l4");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
